seg_digit_driver: RTL

- Downstream consumer of the 8-digit active-low one-hot anode rotator; turns a 32-bit hex value into per-digit cathode patterns for the 8-digit seven-segment display.
- Holds a pending/display register pair so new values commit only at a frame boundary (anode wraps to 8'hFE), which prevents tearing.
- Inserts a programmable anode-blanking gap after every anode change to suppress ghosting.
- Optionally suppresses leading zeros.

---
 rtl/seg_digit_driver.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seg_digit_driver.sv
// Eight-digit seven-segment cathode driver: follows the anode rotator, blanks after each
// anode change, and commits new display values only at frame boundaries.
module seg_digit_driver #(
  parameter int BLANK_CYCLES = 4,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic        busy,
  output logic        load_ack,
  input  logic [7:0]  anode_in,
  output logic [7:0]  anode_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic        frame_tick
);

  localparam logic [0:0] ST_DRIVE = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;
  localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES);

  logic [7:0]  anode_q;
  logic [0:0]  state;
  logic [3:0]  blank_cnt;
  logic [31:0] pend_data;
  logic [31:0] disp_data;
  logic [7:0]  pend_dp;
  logic [7:0]  disp_dp;

  logic        change;
  logic        boundary;
  logic        commit;
  logic        blank_now;
  logic        digit_valid;
  logic [2:0]  digit_idx;
  logic [3:0]  zero_cnt;
  logic [3:0]  nibble;
  logic        suppress;
  logic [31:0] upper_data;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign change    = (anode_in != anode_q);
  assign boundary  = (anode_in == 8'hFE) && (anode_q != 8'hFE);
  assign commit    = boundary && busy;
  // A change blanks the output on the very edge it is seen, before the FSM enters BLANK.
  assign blank_now = (state == ST_BLANK) || (change && (BLANK_CYCLES != 0));

  always_comb begin
    zero_cnt  = 4'd0;
    digit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!anode_q[i]) begin
        zero_cnt  = zero_cnt + 4'd1;
        digit_idx = 3'(i);
      end
    end
    digit_valid = (zero_cnt == 4'd1);
  end

  assign nibble     = disp_data[{digit_idx, 2'b00} +: 4];
  assign upper_data = disp_data >> {digit_idx, 2'b00};
  // Blank a digit when it and everything above it is zero, unless its own dp is lit.
  assign suppress   = LZ_SUPPRESS && (digit_idx != 3'd0) && (upper_data == 32'h0) &&
                      !disp_dp[digit_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode_q   <= 8'hFF;
      state     <= ST_DRIVE;
      blank_cnt <= 4'd0;
    end else begin
      anode_q <= anode_in;
      if (change && (BLANK_CYCLES != 0)) begin
        state     <= ST_BLANK;
        blank_cnt <= BLANK_LOAD;
      end else if (state == ST_BLANK) begin
        if (blank_cnt <= 4'd1) begin
          state     <= ST_DRIVE;
          blank_cnt <= 4'd0;
        end else begin
          blank_cnt <= blank_cnt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_data  <= 32'h0;
      pend_dp    <= 8'h0;
      disp_data  <= 32'h0;
      disp_dp    <= 8'h0;
      busy       <= 1'b0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      load_ack   <= commit;
      if (commit) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        busy      <= 1'b1;
      end else if (commit) begin
        busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode_out <= 8'hFF;
      seg_out   <= 7'h7F;
      dp_out    <= 1'b1;
    end else if (blank_now || !digit_valid) begin
      anode_out <= 8'hFF;
      seg_out   <= 7'h7F;
      dp_out    <= 1'b1;
    end else begin
      anode_out <= anode_q;
      seg_out   <= suppress ? 7'h7F : hex_to_seg(nibble);
      dp_out    <= ~disp_dp[digit_idx];
    end
  end

endmodule
